// File: rtl/debug_overlay_renderer_pkg.sv
// Shared definitions for the debug overlay: glyph size, 8x8 digit font and converter states.
package debug_overlay_renderer_pkg;

    localparam int FONT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_t;

    // One glyph per entry, row 0 in the top byte, column 0 in bit 7 of each row.
    localparam logic [63:0] DIGIT_FONT [10] = '{
        64'h3C666E7666663C00,
        64'h1838181818187E00,
        64'h3C66060C30607E00,
        64'h3C66061C06663C00,
        64'h0C1C3C6C7E0C0C00,
        64'h7E607C0606663C00,
        64'h3C607C6666663C00,
        64'h7E060C1830303000,
        64'h3C66663C66663C00,
        64'h3C66663E060C3800
    };

    function automatic logic [7:0] font_row(input logic [3:0] digit, input logic [2:0] row);
        logic [63:0] glyph;
        glyph = 64'h0;
        if (digit <= 4'd9) glyph = DIGIT_FONT[digit];
        return glyph[{~row, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/debug_overlay_renderer_conv.sv
// Serial shift-add-3 binary to BCD converter; saturates to all nines when the value does not fit.
module serial_bin_to_bcd #(
    parameter int SEQ_LEN = 16,
    parameter int DIGITS  = SEQ_LEN / 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [SEQ_LEN-1:0]  value,
    output logic                busy,
    output logic                done,
    output logic [DIGITS*4-1:0] bcd
);
    import debug_overlay_renderer_pkg::*;

    // State | meaning
    // IDLE  | waiting for start, result held by the consumer
    // SHIFT | one add-3 / shift step per cycle, SEQ_LEN steps
    // COMMIT| result (or saturation) presented with done
    localparam int ACC_W = (DIGITS + 1) * 4;
    localparam int CNT_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

    conv_state_t        state;
    logic [SEQ_LEN-1:0] bin_sr;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic               lost_msb;
    logic [CNT_W-1:0]   cnt;
    logic               overflow;

    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < DIGITS + 1; i++) begin
            if (acc[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
        end
    end

    // The spare top nibble plus a sticky shift-out bit catch every value above 10^DIGITS-1.
    assign overflow = lost_msb || (acc[ACC_W-1 -: 4] != 4'd0);
    assign bcd      = overflow ? {DIGITS{4'h9}} : acc[DIGITS*4-1:0];
    assign done     = (state == COMMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bin_sr   <= '0;
            acc      <= '0;
            lost_msb <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr   <= value;
                        acc      <= '0;
                        lost_msb <= 1'b0;
                        cnt      <= CNT_W'(SEQ_LEN - 1);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    {acc, bin_sr} <= {acc_adj[ACC_W-2:0], bin_sr, 1'b0};
                    lost_msb      <= lost_msb | acc_adj[ACC_W-1];
                    cnt           <= cnt - 1'b1;
                    if (cnt == '0) state <= COMMIT;
                end
                COMMIT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/debug_overlay_renderer.sv
// Draws a once-per-frame snapshot of a debug value as scaled decimal glyphs over the VGA stream.
module debug_overlay_renderer #(
    parameter int                     SEQ_LEN     = 16,
    parameter int                     DIGITS      = SEQ_LEN / 4,
    parameter int                     PIXEL_WIDTH = 12,
    parameter int                     FONT_WIDTH  = debug_overlay_renderer_pkg::FONT_WIDTH,
    parameter int                     SCALE_LOG2  = 1,
    parameter int                     X0          = 16,
    parameter int                     Y0          = 16,
    parameter logic [PIXEL_WIDTH-1:0] FG_COLOR    = 12'h000,
    parameter int                     H_W         = 10,
    parameter int                     V_W         = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_start,
    input  logic [SEQ_LEN-1:0]     value,
    input  logic [H_W-1:0]         h_cnt,
    input  logic [V_W-1:0]         v_cnt,
    input  logic                   pix_valid,
    input  logic [PIXEL_WIDTH-1:0] bg_pixel,
    output logic [PIXEL_WIDTH-1:0] out_pixel,
    output logic                   out_valid,
    output logic                   conv_busy,
    output logic [DIGITS*4-1:0]    shown_bcd
);
    import debug_overlay_renderer_pkg::*;

    localparam int           GLYPH_SHIFT = $clog2(FONT_WIDTH) + SCALE_LOG2;
    localparam logic [H_W:0] X0_X        = (H_W + 1)'(X0);
    localparam logic [H_W:0] WIN_W_X     = (H_W + 1)'((DIGITS * FONT_WIDTH) << SCALE_LOG2);
    localparam logic [V_W:0] Y0_X        = (V_W + 1)'(Y0);
    localparam logic [V_W:0] WIN_H_X     = (V_W + 1)'(FONT_WIDTH << SCALE_LOG2);

    logic                conv_done;
    logic [DIGITS*4-1:0] conv_bcd;

    serial_bin_to_bcd #(
        .SEQ_LEN (SEQ_LEN),
        .DIGITS  (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (frame_start),
        .value (value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         shown_bcd <= '0;
        else if (conv_done) shown_bcd <= conv_bcd;
    end

    logic [H_W:0] dx;
    logic [V_W:0] dy;
    logic [H_W:0] dig_idx;
    logic         in_win;
    logic [3:0]   nib;

    always_comb begin
        dx      = {1'b0, h_cnt} - X0_X;
        dy      = {1'b0, v_cnt} - Y0_X;
        in_win  = ({1'b0, h_cnt} >= X0_X) && (dx < WIN_W_X) &&
                  ({1'b0, v_cnt} >= Y0_X) && (dy < WIN_H_X);
        dig_idx = dx >> GLYPH_SHIFT;
        nib     = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_idx == (H_W + 1)'(i)) nib = shown_bcd[(DIGITS-1-i)*4 +: 4];
        end
    end

    logic                   win_d;
    logic [3:0]             nib_d;
    logic [2:0]             col_d;
    logic [2:0]             row_d;
    logic [PIXEL_WIDTH-1:0] bg_d;
    logic                   valid_d;
    logic [7:0]             row_bits;

    assign row_bits = font_row(nib_d, row_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_d     <= 1'b0;
            nib_d     <= '0;
            col_d     <= '0;
            row_d     <= '0;
            bg_d      <= '0;
            valid_d   <= 1'b0;
            out_pixel <= '0;
            out_valid <= 1'b0;
        end else begin
            win_d     <= in_win;
            nib_d     <= nib;
            col_d     <= dx[SCALE_LOG2 +: 3];
            row_d     <= dy[SCALE_LOG2 +: 3];
            bg_d      <= bg_pixel;
            valid_d   <= pix_valid;
            // Glyph column 0 is the leftmost pixel, held in bitmap bit 7.
            out_pixel <= (win_d && row_bits[~col_d]) ? FG_COLOR : bg_d;
            out_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_debug_overlay_renderer.sv
// Randomized bench for debug_overlay_renderer against a decimal/pixel reference model.
module tb_debug_overlay_renderer;

    localparam int          SEQ_LEN    = 16;
    localparam int          DIGITS     = 4;
    localparam int          PW         = 12;
    localparam int          SCALE_LOG2 = 1;
    localparam int          X0         = 16;
    localparam int          Y0         = 16;
    localparam int          H_W        = 10;
    localparam int          V_W        = 10;
    localparam logic [11:0] FG         = 12'h000;

    logic               clk;
    logic               rst_n;
    logic               frame_start;
    logic [SEQ_LEN-1:0] value;
    logic [H_W-1:0]     h_cnt;
    logic [V_W-1:0]     v_cnt;
    logic               pix_valid;
    logic [PW-1:0]      bg_pixel;
    logic [PW-1:0]      out_pixel;
    logic               out_valid;
    logic               conv_busy;
    logic [DIGITS*4-1:0] shown_bcd;

    debug_overlay_renderer #(
        .SEQ_LEN(SEQ_LEN), .DIGITS(DIGITS), .PIXEL_WIDTH(PW), .FONT_WIDTH(8),
        .SCALE_LOG2(SCALE_LOG2), .X0(X0), .Y0(Y0), .FG_COLOR(FG), .H_W(H_W), .V_W(V_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .value(value),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .pix_valid(pix_valid), .bg_pixel(bg_pixel),
        .out_pixel(out_pixel), .out_valid(out_valid), .conv_busy(conv_busy),
        .shown_bcd(shown_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [15:0] model_shown = 16'h0000;
    logic [11:0] q_pix[$];
    logic        q_val[$];

    logic [7:0] font_tb [10][8] = '{
        '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},
        '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00}
    };

    function automatic logic [15:0] model_bcd(int v);
        int d;
        d = (v > 9999) ? 9999 : v;
        return 16'((d / 1000) * 4096 + ((d / 100) % 10) * 256 + ((d / 10) % 10) * 16 + d % 10);
    endfunction

    function automatic logic [11:0] model_pixel(int h, int v, logic [11:0] bg, logic [15:0] shown);
        int scale, dx, dy, dig, col, row;
        logic [3:0] nib;
        logic [7:0] bits;
        scale = 1 << SCALE_LOG2;
        dx = h - X0;
        dy = v - Y0;
        if (dx < 0 || dy < 0 || dx >= DIGITS * 8 * scale || dy >= 8 * scale) return bg;
        dig = dx / (8 * scale);
        col = (dx / scale) % 8;
        row = (dy / scale) % 8;
        nib = shown[(DIGITS - 1 - dig) * 4 +: 4];
        if (nib > 4'd9) return bg;
        bits = font_tb[nib][row];
        return bits[7 - col] ? FG : bg;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; frame_start = 1'b0; value = '0; h_cnt = '0; v_cnt = '0;
        pix_valid = 1'b0; bg_pixel = '0;
        repeat (3) @(negedge clk);
        checks++; if (shown_bcd !== 16'h0000) begin errors++; $display("FAIL reset_shown got=%h exp=0000", shown_bcd); end
        checks++; if (conv_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", conv_busy); end
        checks++; if (out_pixel !== 12'h000) begin errors++; $display("FAIL reset_pixel got=%h exp=000", out_pixel); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Pulse frame_start, then scramble value; busy must hold 17 edges and shown update on edge 18.
    task automatic run_conversion(logic [15:0] v);
        logic [15:0] old_bcd, exp_bcd;
        old_bcd = model_shown;
        exp_bcd = model_bcd(int'(v));
        @(negedge clk);
        value = v; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        value = 16'($urandom);
        for (int k = 1; k <= 18; k++) begin
            if (k > 1) @(negedge clk);
            if (k < 18) begin
                checks++; if (conv_busy !== 1'b1) begin errors++; $display("FAIL conv_busy v=%0d edge=%0d got=%b exp=1", v, k, conv_busy); end
                checks++; if (shown_bcd !== old_bcd) begin errors++; $display("FAIL conv_early v=%0d edge=%0d got=%h exp=%h", v, k, shown_bcd, old_bcd); end
            end else begin
                checks++; if (conv_busy !== 1'b0) begin errors++; $display("FAIL conv_done_busy v=%0d got=%b exp=0", v, conv_busy); end
                checks++; if (shown_bcd !== exp_bcd) begin errors++; $display("FAIL conv_result v=%0d got=%h exp=%h", v, shown_bcd, exp_bcd); end
            end
        end
        model_shown = exp_bcd;
    endtask

    task automatic test_conversions();
        run_conversion(16'd1234);
        run_conversion(16'd65535);
        run_conversion(16'd9999);
        run_conversion(16'd10000);
        run_conversion(16'd0);
        for (int i = 0; i < 4; i++) run_conversion(16'($urandom_range(0, 9999)));
        for (int i = 0; i < 2; i++) run_conversion(16'($urandom_range(0, 65535)));
        run_conversion(16'd1234);
    endtask

    task automatic drive_pixel(int h, int v, logic [11:0] bg, logic pv);
        logic [11:0] ep;
        logic        ev;
        @(negedge clk);
        if (q_pix.size() >= 2) begin
            ep = q_pix.pop_front();
            ev = q_val.pop_front();
            checks++; if (out_pixel !== ep) begin errors++; $display("FAIL pixel got=%h exp=%h", out_pixel, ep); end
            checks++; if (out_valid !== ev) begin errors++; $display("FAIL out_valid got=%b exp=%b", out_valid, ev); end
        end
        h_cnt = H_W'(h); v_cnt = V_W'(v); bg_pixel = bg; pix_valid = pv;
        q_pix.push_back(model_pixel(h, v, bg, model_shown));
        q_val.push_back(pv);
    endtask

    task automatic test_render();
        q_pix.delete();
        q_val.delete();
        drive_pixel(X0 + 6, Y0, 12'h5A5, 1'b1);
        drive_pixel(X0 + 4, Y0, 12'h5A5, 1'b1);
        drive_pixel(0, 0, 12'hABC, 1'b1);
        drive_pixel(0, 0, 12'hABC, 1'b0);
        drive_pixel(0, 0, 12'hABC, 1'b1);
        for (int i = 0; i < 300; i++)
            drive_pixel(int'($urandom_range(0, 100)), int'($urandom_range(0, 40)),
                        12'($urandom), 1'($urandom));
        while (q_pix.size() > 0) begin
            @(negedge clk);
            pix_valid = 1'b0;
            checks++; if (out_pixel !== q_pix[0]) begin errors++; $display("FAIL pixel_tail got=%h exp=%h", out_pixel, q_pix[0]); end
            checks++; if (out_valid !== q_val[0]) begin errors++; $display("FAIL valid_tail got=%b exp=%b", out_valid, q_val[0]); end
            void'(q_pix.pop_front());
            void'(q_val.pop_front());
        end
    endtask

    task automatic test_mid_frame_change();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            value = 16'($urandom);
        end
        checks++; if (shown_bcd !== model_shown) begin errors++; $display("FAIL mid_frame got=%h exp=%h", shown_bcd, model_shown); end
        checks++; if (conv_busy !== 1'b0) begin errors++; $display("FAIL mid_frame_busy got=%b exp=0", conv_busy); end
    endtask

    task automatic test_back_to_back();
        int a, b;
        a = int'($urandom_range(0, 9999));
        b = (a + 1234) % 10000;
        @(negedge clk);
        value = 16'(a); frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (4) @(negedge clk);
        value = 16'(b); frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (shown_bcd !== model_bcd(a)) begin errors++; $display("FAIL b2b_commit got=%h exp=%h", shown_bcd, model_bcd(a)); end
        checks++; if (conv_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got=%b exp=0", conv_busy); end
        repeat (20) @(negedge clk);
        checks++; if (shown_bcd !== model_bcd(a)) begin errors++; $display("FAIL b2b_no_restart got=%h exp=%h", shown_bcd, model_bcd(a)); end
        model_shown = model_bcd(a);
    endtask

    task automatic test_reset_mid_conversion();
        @(negedge clk);
        value = 16'($urandom_range(0, 9999)); frame_start = 1'b1;
        pix_valid = 1'b1; h_cnt = '0; v_cnt = '0; bg_pixel = 12'($urandom);
        @(negedge clk);
        frame_start = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (conv_busy !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset busy=%b valid=%b exp=1,1", conv_busy, out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (shown_bcd !== 16'h0000) begin errors++; $display("FAIL async_shown got=%h exp=0000", shown_bcd); end
        checks++; if (conv_busy !== 1'b0) begin errors++; $display("FAIL async_busy got=%b exp=0", conv_busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_valid got=%b exp=0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1; pix_valid = 1'b0;
        model_shown = 16'h0000;
        repeat (20) @(negedge clk);
        checks++; if (shown_bcd !== 16'h0000 || conv_busy !== 1'b0) begin errors++; $display("FAIL post_reset shown=%h busy=%b exp=0000,0", shown_bcd, conv_busy); end
        run_conversion(16'($urandom_range(0, 65535)));
    endtask

    initial begin
        test_reset();
        test_conversions();
        test_render();
        test_mid_frame_change();
        test_back_to_back();
        test_render();
        test_reset_mid_conversion();
        test_render();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
